// File: rtl/add_sub_pipe_pkg.sv
// Shared definitions for the carry-segmented pipelined adder/subtractor.
package add_sub_pipe_pkg;

  // Operation selected by the sel input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Width of one carry segment.
  function automatic int seg_w(input int width, input int segments);
    return width / segments;
  endfunction

  // True when the WIDTH/SEGMENTS pair splits into equal, non-empty slices.
  function automatic bit seg_cfg_ok(input int width, input int segments);
    return (segments >= 1) && (segments <= width) && ((width % segments) == 0);
  endfunction

endpackage

// File: rtl/add_sub_seg.sv
// One carry segment: SEG_W-bit add of a, b and carry-in, with carry-out.
module add_sub_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  logic [SEG_W:0] w_full;

  // Widen by one bit so the native adder produces the carry-out directly.
  assign w_full = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  assign sum    = w_full[SEG_W-1:0];
  assign cout   = w_full[SEG_W];

endmodule

// File: rtl/add_sub_pipe.sv
// Carry-segmented pipelined adder/subtractor with valid/ready on both sides.
// Stage k holds the full operands, the partial sum for segments below k and
// the carry into segment k; segment k is added between stage k and k+1, so
// the operand skew and result deskew fall out of carrying whole words along.
module add_sub_pipe
  import add_sub_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SEGMENTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG_W = seg_w(WIDTH, SEGMENTS);
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = SEGMENTS - 1;

  if (!seg_cfg_ok(WIDTH, SEGMENTS)) begin : g_cfg_err
    $error("add_sub_pipe: WIDTH (%0d) must be a multiple of SEGMENTS (%0d), 1 <= SEGMENTS <= WIDTH",
           WIDTH, SEGMENTS);
  end

  // Pipeline stage registers, index = stage.
  logic [WIDTH-1:0]    r_a_p   [SEGMENTS];
  logic [WIDTH-1:0]    r_b_p   [SEGMENTS];
  logic [WIDTH-1:0]    r_sum_p [SEGMENTS];
  logic                r_cin_p [SEGMENTS];
  logic [SEGMENTS-1:0] r_vld_p;

  // Output register.
  logic             r_out_vld;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_ovf;

  // Per-segment combinational results.
  logic [WIDTH-1:0] w_merged [SEGMENTS];
  logic             w_cout   [SEGMENTS];
  logic             w_en;
  logic             w_ovf;
  op_e              w_op;

  // One global enable: the whole pipe advances unless the output is held.
  assign w_en     = !r_out_vld || out_ready;
  assign in_ready = w_en;
  assign w_op     = sel ? OP_SUB : OP_ADD;

  for (genvar g = 0; g < SEGMENTS; g++) begin : g_seg
    logic [SEG_W-1:0] w_seg_sum;
    logic [WIDTH-1:0] w_merge;

    add_sub_seg #(
      .SEG_W(SEG_W)
    ) u_seg (
      .a   (r_a_p[g][g*SEG_W +: SEG_W]),
      .b   (r_b_p[g][g*SEG_W +: SEG_W]),
      .cin (r_cin_p[g]),
      .sum (w_seg_sum),
      .cout(w_cout[g])
    );

    // Insert this segment's sum into the partial result word.
    always_comb begin
      w_merge                      = r_sum_p[g];
      w_merge[g*SEG_W +: SEG_W]    = w_seg_sum;
    end

    assign w_merged[g] = w_merge;
  end

  // Signed overflow from the aligned operand MSBs and the final result MSB.
  assign w_ovf = (r_a_p[LAST][MSB] == r_b_p[LAST][MSB]) &&
                 (w_merged[LAST][MSB] != r_a_p[LAST][MSB]);

  // Data pipeline (no reset): capture operands, then advance one segment per stage.
  always_ff @(posedge clk) begin
    if (w_en) begin
      // stage p0: operands with subtrahend inverted, carry-in = sel
      r_a_p[0]   <= in0;
      r_b_p[0]   <= (w_op == OP_SUB) ? ~in1 : in1;
      r_cin_p[0] <= (w_op == OP_SUB);
      r_sum_p[0] <= '0;
      // stage pk -> pk+1: segment k result and carry move on
      for (int k = 0; k < SEGMENTS - 1; k++) begin
        r_a_p[k+1]   <= r_a_p[k];
        r_b_p[k+1]   <= r_b_p[k];
        r_cin_p[k+1] <= w_cout[k];
        r_sum_p[k+1] <= w_merged[k];
      end
    end
  end

  // Control and output register: valid bits and the result word reset asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p   <= '0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_en) begin
      r_vld_p[0] <= in_valid;
      for (int k = 1; k < SEGMENTS; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
      end
      // last stage -> output: final segment completes the word
      r_out_vld <= r_vld_p[LAST];
      r_out     <= w_merged[LAST];
      r_cout    <= w_cout[LAST];
      r_ovf     <= w_ovf;
    end
  end

  assign out_valid = r_out_vld;
  assign out       = r_out;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: three instances (SEGMENTS = 4, 1, 32) exercised in turn.
module tb_add_sub_pipe;

  localparam int W  = 32;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [ND-1:0]         in_valid, in_ready, sel, out_valid, out_ready, cout, ovf;
  logic [ND-1:0][W-1:0]  in0, in1, out;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    add_sub_pipe #(
      .WIDTH(W),
      .SEGMENTS(S)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in0      (in0[g]),
      .in1      (in1[g]),
      .sel      (sel[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out      (out[g]),
      .cout     (cout[g]),
      .ovf      (ovf[g])
    );
  end

  function automatic int seg_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (SEGMENTS=%0d): got 0x%0h required 0x%0h", name, seg_of(d), act, exp);
    end
  endtask

  // Independent full-width reference: {ovf, cout, out}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] adj;
    logic [32:0] r;
    logic        v;
    adj = s ? ~b : b;
    r   = {1'b0, a} + {1'b0, adj} + {32'd0, s};
    v   = (a[31] == adj[31]) && (r[31] != a[31]);
    return {v, r[32], r[31:0]};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs [10];

  // Single transaction with out_ready=1: checks latency, result and that only one result appears.
  task automatic run_one(input int d, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] er, input logic ec, input logic ev, input string name);
    int n;
    @(negedge clk);
    in0[d] = a; in1[d] = b; sel[d] = s; in_valid[d] = 1'b1; out_ready[d] = 1'b1;
    #1;
    check($sformatf("%s_in_ready", name), d, 64'(in_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s_latency", name), d, 64'(n), 64'(seg_of(d)));
    check($sformatf("%s_out", name), d, 64'(out[d]), 64'(er));
    check($sformatf("%s_cout", name), d, 64'(cout[d]), 64'(ec));
    check($sformatf("%s_ovf", name), d, 64'(ovf[d]), 64'(ev));
    @(posedge clk);
    #1;
    check($sformatf("%s_single", name), d, 64'(out_valid[d]), 64'd0);
  endtask

  // Random stream with gaps and ~50% out_ready; scoreboard compares in order.
  task automatic stream(input int d);
    logic [33:0] expq [$];
    logic [33:0] exp_v;
    logic [31:0] held_out;
    logic        held_c, held_v;
    logic        holding, stall_prev;
    int          sent, recv, cyc;
    holding = 1'b0; stall_prev = 1'b0; sent = 0; recv = 0; cyc = 0;
    held_out = '0; held_c = 1'b0; held_v = 1'b0;
    while (recv < 64 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!holding) begin
        if (sent < 64 && $urandom_range(0, 2) != 0) begin
          in_valid[d] = 1'b1;
          in0[d]      = $urandom;
          in1[d]      = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
          sel[d]      = 1'($urandom_range(0, 1));
        end else begin
          in_valid[d] = 1'b0;
        end
      end
      out_ready[d] = 1'($urandom_range(0, 1));
      #1;
      if (stall_prev) begin
        check("stream_hold_valid", d, 64'(out_valid[d]), 64'd1);
        check("stream_hold_out", d, {30'd0, ovf[d], cout[d], out[d]}, {30'd0, held_v, held_c, held_out});
      end
      if (in_valid[d] && in_ready[d]) begin
        expq.push_back(model(in0[d], in1[d], sel[d]));
        sent++;
        holding = 1'b0;
      end else begin
        holding = in_valid[d];
      end
      if (out_valid[d] && out_ready[d]) begin
        if (expq.size() == 0) begin
          check("stream_spurious", d, 64'd1, 64'd0);
        end else begin
          exp_v = expq.pop_front();
          check($sformatf("stream_result_%0d", recv), d,
                {30'd0, ovf[d], cout[d], out[d]}, {30'd0, exp_v});
        end
        recv++;
      end
      stall_prev = out_valid[d] && !out_ready[d];
      held_out = out[d]; held_c = cout[d]; held_v = ovf[d];
    end
    @(negedge clk);
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    check("stream_count", d, 64'(recv), 64'd64);
    check("stream_sent", d, 64'(sent), 64'd64);
  endtask

  // Load work, stall it at the output, then reset asynchronously mid-cycle.
  task automatic reset_mid(input int d);
    int n;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in0[d] = 32'hC000_0000; in1[d] = 32'h8000_0001; sel[d] = 1'b0;
      in_valid[d] = 1'b1; out_ready[d] = 1'b1;
    end
    @(negedge clk);
    in_valid[d] = 1'b0; out_ready[d] = 1'b0;
    n = 0;
    while (!out_valid[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_preload_valid", d, 64'(out_valid[d]), 64'd1);
    check("rst_preload_out", d, {62'd0, ovf[d], cout[d]}, 64'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", d, 64'(out_valid[d]), 64'd0);
    check("rst_async_out", d, 64'(out[d]), 64'd0);
    check("rst_async_flags", d, {62'd0, ovf[d], cout[d]}, 64'd0);
    check("rst_in_ready", d, 64'(in_ready[d]), 64'd1);
    @(negedge clk);
    rst = 1'b0; out_ready[d] = 1'b1;
    run_one(d, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = '0;
    sel       = '0;
    out_ready = '1;
    in0       = '0;
    in1       = '0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("reset_valid", d, 64'(out_valid[d]), 64'd0);
      check("reset_out", d, 64'(out[d]), 64'd0);
      check("reset_flags", d, {62'd0, ovf[d], cout[d]}, 64'd0);
      check("reset_in_ready", d, 64'(in_ready[d]), 64'd1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 10; i++) begin
        run_one(d, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].v,
                $sformatf("vec%0d", i));
      end
      stream(d);
      reset_mid(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
